// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler: issues one FP operation at a time to four arithmetic units and returns the result.
// Illegal opcodes and hung units both answer with a quiet NaN and err set.
module fpu_op_scheduler #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  opcode,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [3:0]  unit_start,
    input  logic [3:0]  unit_done,
    output logic [2:0]  mux_sel,
    input  logic [31:0] res_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        err,
    output logic        busy
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic done_sel, timeout;
    assign done_sel = unit_done[mux_sel[1:0]];
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    // Control outputs are forced low during reset so nothing leaks from an abandoned operation.
    always_comb begin
        next = state;
        in_ready = 1'b0;
        unit_start = 4'b0000;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) next = ISSUE;
            end
            ISSUE: begin
                unit_start = (rst || mux_sel[2]) ? 4'b0000 : 4'b0001 << mux_sel[1:0];
                next = mux_sel[2] ? RESP : WAIT;
            end
            WAIT: if (done_sel || timeout) next = RESP;
            RESP: begin
                out_valid = !rst;
                if (out_ready) next = IDLE;
            end
            default: next = IDLE;
        endcase
        busy = !rst && state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_sel <= '0;
            op_a <= '0;
            op_b <= '0;
            result <= '0;
            err <= 1'b0;
            cnt <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                mux_sel <= opcode;
                op_a <= operand_a;
                op_b <= operand_b;
            end
            if (state == ISSUE) begin
                cnt <= '0;
                if (mux_sel[2]) begin
                    result <= QNAN;
                    err <= 1'b1;
                end
            end
            // Done has priority over timeout when both land in the same cycle.
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (done_sel) begin
                    result <= res_in;
                    err <= 1'b0;
                end else if (timeout) begin
                    result <= QNAN;
                    err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_op_scheduler.sv
// tb_fpu_op_scheduler: directed vector bench; one instance at default timeout, one at TIMEOUT_CYCLES=8.
module tb_fpu_op_scheduler;
    logic clk = 1'b0;
    logic rst, in_valid, out_ready, use8;
    logic [2:0] opcode;
    logic [31:0] operand_a, operand_b, res_in;
    logic [3:0] unit_done;
    logic ir64, ov64, err64, busy64, ir8, ov8, err8, busy8;
    logic [31:0] opa64, opb64, res64, opa8, opb8, res8;
    logic [3:0] us64, us8;
    logic [2:0] ms64, ms8;
    logic in_ready, out_valid, err, busy;
    logic [31:0] op_a, op_b, result;
    logic [3:0] unit_start;
    logic [2:0] mux_sel;
    int nvec = 0, nmis = 0;

    always #5 clk = ~clk;

    fpu_op_scheduler dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !use8), .in_ready(ir64), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .op_a(opa64), .op_b(opb64),
        .unit_start(us64), .unit_done(unit_done), .mux_sel(ms64), .res_in(res_in),
        .out_valid(ov64), .out_ready(out_ready), .result(res64), .err(err64), .busy(busy64)
    );
    fpu_op_scheduler #(.TIMEOUT_CYCLES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid && use8), .in_ready(ir8), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b), .op_a(opa8), .op_b(opb8),
        .unit_start(us8), .unit_done(unit_done), .mux_sel(ms8), .res_in(res_in),
        .out_valid(ov8), .out_ready(out_ready), .result(res8), .err(err8), .busy(busy8)
    );

    assign in_ready = use8 ? ir8 : ir64;
    assign out_valid = use8 ? ov8 : ov64;
    assign err = use8 ? err8 : err64;
    assign busy = use8 ? busy8 : busy64;
    assign op_a = use8 ? opa8 : opa64;
    assign op_b = use8 ? opb8 : opb64;
    assign result = use8 ? res8 : res64;
    assign unit_start = use8 ? us8 : us64;
    assign mux_sel = use8 ? ms8 : ms64;

    typedef struct {
        logic [2:0] op;
        logic [31:0] a, b, res;
        int done_cyc;
        logic [3:0] done_val;
        int hold;
        logic sel8;
        logic [3:0] exp_start;
        int exp_fv;
        logic [31:0] exp_res;
        logic exp_err;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc, fv;
        @(posedge clk); #1;
        use8 = v.sel8;
        opcode = v.op;
        operand_a = v.a;
        operand_b = v.b;
        res_in = v.res;
        out_ready = 1'b0;
        in_valid = 1'b1;
        cyc = 0;
        fv = -1;
        while (fv < 0 && cyc < 200) begin
            unit_done = (cyc == v.done_cyc) ? v.done_val : 4'b0000;
            @(negedge clk);
            if (cyc == 0) check("in_ready_idle", in_ready, 1);
            if (cyc == 1) begin
                check("unit_start", unit_start, v.exp_start);
                check("busy_issue", busy, 1);
            end
            if (cyc == 2) check("start_clear", unit_start, 0);
            if (out_valid) fv = cyc;
            else begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                cyc++;
            end
        end
        check("latency", fv, v.exp_fv);
        check("result", result, v.exp_res);
        check("err", err, v.exp_err);
        check("mux_sel", mux_sel, v.op);
        check("op_a", op_a, v.a);
        check("op_b", op_b, v.b);
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            unit_done = 4'b0000;
            res_in = 32'hDEADBEEF;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_result", result, v.exp_res);
            check("hold_err", err, v.exp_err);
            check("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        unit_done = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_resp", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_after", in_ready, 1);
        check("valid_after", out_valid, 0);
    endtask

    initial begin
        vt[0] = '{3'd0, 32'h3F800000, 32'h40000000, 32'h40400000, 3, 4'b0001, 0, 1'b0, 4'b0001, 4, 32'h40400000, 1'b0};
        vt[1] = '{3'd3, 32'h40C00000, 32'h40000000, 32'h40400000, 20, 4'b1000, 5, 1'b0, 4'b1000, 21, 32'h40400000, 1'b0};
        vt[2] = '{3'd5, 32'h11111111, 32'h22222222, 32'h12345678, -1, 4'b0000, 0, 1'b0, 4'b0000, 2, 32'h7FC00000, 1'b1};
        vt[3] = '{3'd2, 32'h40000000, 32'h40400000, 32'h40C00000, 3, 4'b0001, 0, 1'b1, 4'b0100, 10, 32'h7FC00000, 1'b1};
        vt[4] = '{3'd2, 32'h40000000, 32'h40000000, 32'h40800000, 2, 4'b0100, 0, 1'b1, 4'b0100, 3, 32'h40800000, 1'b0};
        vt[5] = '{3'd1, 32'h40A00000, 32'h3F800000, 32'h40800000, 9, 4'b0010, 1, 1'b1, 4'b0010, 10, 32'h40800000, 1'b0};
        vt[6] = '{3'd7, 32'hAAAAAAAA, 32'h55555555, 32'h0, 2, 4'b1111, 0, 1'b0, 4'b0000, 2, 32'h7FC00000, 1'b1};
        rst = 1'b1;
        use8 = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        opcode = '0;
        operand_a = '0;
        operand_b = '0;
        res_in = '0;
        unit_done = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_unit_start", unit_start, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_mux_sel", mux_sel, 0);
        check("rst_op_a", op_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_post_rst", in_ready, 1);
        for (int i = 0; i < 7; i++) run_vec(vt[i]);
        // Reset in the WAIT state of a mul, followed by a late done for that unit.
        @(posedge clk); #1;
        use8 = 1'b0;
        opcode = 3'd2;
        operand_a = 32'h40400000;
        operand_b = 32'h40400000;
        res_in = 32'h41100000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mw_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mw_rst_in_ready", in_ready, 0);
        check("mw_rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        unit_done = 4'b0100;
        @(negedge clk);
        check("mw_in_ready", in_ready, 1);
        check("mw_mux_sel", mux_sel, 0);
        check("mw_op_a", op_a, 0);
        check("mw_op_b", op_b, 0);
        check("mw_result", result, 0);
        check("mw_err", err, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            unit_done = 4'b0000;
            @(negedge clk);
            check("mw_no_valid", out_valid, 0);
            check("mw_idle", busy, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
